peg_scorer: RTL
===============

PEG_SCORER -- requirements
Module: peg_scorer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; resetn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: colour_in  in  3  colour value from switches.
REQ-003 SHALL have: load_code_1..load_code_4  in  1 each  level write enables for secret-code slots 0..3.
REQ-004 SHALL have: load_guess_1..load_guess_4  in  1 each  level write enables for guess slots 0..3.
REQ-005 SHALL have: compare  in  1  score-step strobe; compare_i  in  2  slot index for this step.
REQ-006 SHALL have: reach_result_3  in  1  final score step marker.
REQ-007 SHALL have: black  out  3  exact-position matches (0..4); white  out  3  colour-only matches (0..4).
REQ-008 SHALL have: result_valid  out  1  one-cycle pulse, new score; win  out  1  sticky, last score was 4 black.
REQ-009 SHALL have: guess_count  out  4  scored guesses since new code; game_over  out  1  guess limit hit.

Function
REQ-010 SHALL write colour_in into code[k] every cycle load_code_(k+1) is high; last cycle's value wins.
REQ-011 SHALL write colour_in into guess[k] every cycle load_guess_(k+1) is high; last cycle's value wins.
REQ-012 SHALL, on compare with compare_i=k, use code[k] and guess[k] as registered before that edge; a same-cycle load SHALL affect only later steps.
REQ-013 SHALL, on compare with compare_i=0, first clear black_acc, code_hist[0..7] and guess_hist[0..7], then accumulate slot 0.
REQ-014 SHALL, on each compare step k: increment black_acc if code[k]==guess[k]; increment code_hist[code[k]] and guess_hist[guess[k]].
REQ-015 SHALL, on the cycle after a compare step with reach_result_3=1: register black=black_acc, white=sum over colours of min(code_hist,guess_hist) minus black_acc, and pulse result_valid.
REQ-016 SHALL hold black/white between results; they SHALL change only per REQ-015 or per REQ-020.
REQ-017 SHALL set win with result_valid when black_acc==4, and clear it when a later result has black<4.
REQ-018 SHALL increment guess_count on each result_valid pulse, saturating at 15.
REQ-019 SHALL ignore compare steps without a prior index-0 step since the last result; accumulation continues from its current value without error.
REQ-020 SHALL, while any load_code_* is high, clear black, white, win, guess_count, game_over and result_valid.
REQ-021 SHALL give load_code_* (REQ-020) priority over a simultaneous result update.
REQ-022 SHALL keep histogram counters 3 bits wide; a count cannot exceed 4.

Reset
REQ-023 SHALL, with resetn=0 at a clk edge, set code[*]=0, guess[*]=0, all accumulators and histograms=0, black=0, white=0, result_valid=0, win=0, guess_count=0, game_over=0.
REQ-024 SHALL, on reset mid-scoring, discard partial accumulation; no result_valid SHALL follow.

Configuration
REQ-025 SHALL support the macro PEG_SCORER_GUESS_LIMIT_EN.
REQ-026 With the macro defined: game_over SHALL set on the result_valid that makes guess_count reach MAX_GUESSES (10) with win=0, and SHALL stay set until load_code_* or reset.
REQ-027 With the macro defined: while game_over=1, further compare steps SHALL be ignored.
REQ-028 Without the macro: game_over SHALL be constant 0 and compare SHALL never be blocked.

Structure
REQ-029 Package mm_pkg SHALL hold COLOUR_W=3, NUM_PEGS=4, NUM_COLOURS=8, MAX_GUESSES=10 and typedef colour_t.
REQ-030 A sub-module mm_overlap SHALL compute the combinational sum of min(code_hist[c], guess_hist[c]) over all colours; all state SHALL stay in peg_scorer.

Verification
REQ-031 Code 1,2,3,4; guess 1,2,3,4; steps 0..3 -> next cycle result_valid=1, black=4, white=0, win=1, guess_count=1.
REQ-032 Code 1,2,3,4; guess 4,3,2,1 -> black=0, white=4, win=0.
REQ-033 Code 1,1,2,2; guess 1,2,1,5 -> black=1, white=2.
REQ-034 load_code_1 high with guess_count=3, win=1 -> next cycle guess_count=0, win=0, black=0, white=0.
REQ-035 resetn=0 on the cycle after step 1 -> no result_valid, all outputs 0.
REQ-036 PEG_SCORER_GUESS_LIMIT_EN defined, 10 non-winning guesses -> game_over=1 with the 10th result_valid; an 11th step sequence -> no result_valid, guess_count stays 10.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared types and constants for the peg scorer.
//   COLOUR_W    - width of one peg colour
//   NUM_PEGS    - pegs in a code or guess
//   NUM_COLOURS - distinct colours, one histogram bin each
//   MAX_GUESSES - guess limit used when PEG_SCORER_GUESS_LIMIT_EN is defined
package mm_pkg;

  localparam int COLOUR_W    = 3;
  localparam int NUM_PEGS    = 4;
  localparam int NUM_COLOURS = 8;
  localparam int MAX_GUESSES = 10;
  localparam int HIST_W      = 3;
  // Wide enough for a sum of eight bins that each saturate at 4.
  localparam int OVL_W       = 6;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [HIST_W-1:0]   hist_t;
  typedef hist_t [NUM_COLOURS-1:0] hist_arr_t;

  // Increment that stops at NUM_PEGS, because no count can meaningfully exceed it.
  function automatic hist_t sat_inc4(input hist_t v);
    return (v >= hist_t'(NUM_PEGS)) ? v : v + hist_t'(1);
  endfunction

endpackage

// File: rtl/peg_scorer_if.sv
// peg_scorer_if: bundles the peg scorer's data, control and result signals.
//   colour_in        - colour from switches
//   load_code_1..4   - level write enables for secret-code slots 0..3
//   load_guess_1..4  - level write enables for guess slots 0..3
//   compare          - score-step strobe, compare_i selects the slot
//   reach_result_3   - marks the final score step
//   black/white      - exact and colour-only match counts
//   result_valid     - one-cycle pulse when a new score is registered
//   win              - last score had four blacks
//   guess_count      - scored guesses since the last new code (saturates at 15)
//   game_over        - guess limit reached
// Modports: master drives the controls, slave is the scorer.
interface peg_scorer_if;
  import mm_pkg::*;

  colour_t    colour_in;
  logic       load_code_1;
  logic       load_code_2;
  logic       load_code_3;
  logic       load_code_4;
  logic       load_guess_1;
  logic       load_guess_2;
  logic       load_guess_3;
  logic       load_guess_4;
  logic       compare;
  logic [1:0] compare_i;
  logic       reach_result_3;
  logic [2:0] black;
  logic [2:0] white;
  logic       result_valid;
  logic       win;
  logic [3:0] guess_count;
  logic       game_over;

  modport master (
    output colour_in, load_code_1, load_code_2, load_code_3, load_code_4,
    output load_guess_1, load_guess_2, load_guess_3, load_guess_4,
    output compare, compare_i, reach_result_3,
    input  black, white, result_valid, win, guess_count, game_over
  );

  modport slave (
    input  colour_in, load_code_1, load_code_2, load_code_3, load_code_4,
    input  load_guess_1, load_guess_2, load_guess_3, load_guess_4,
    input  compare, compare_i, reach_result_3,
    output black, white, result_valid, win, guess_count, game_over
  );

endinterface

// File: rtl/mm_overlap.sv
// mm_overlap: combinational count of colours shared between code and guess,
// i.e. the sum over all colours of min(code_hist[c], guess_hist[c]).
//   code_hist  - per-colour counts of the secret code
//   guess_hist - per-colour counts of the guess
//   overlap    - total shared colours (blacks included)
module mm_overlap
  import mm_pkg::*;
(
  input  hist_arr_t         code_hist,
  input  hist_arr_t         guess_hist,
  output logic [OVL_W-1:0]  overlap
);

  always_comb begin
    overlap = '0;
    for (int c = 0; c < NUM_COLOURS; c++) begin
      if (code_hist[c] < guess_hist[c]) begin
        overlap = overlap + OVL_W'(code_hist[c]);
      end else begin
        overlap = overlap + OVL_W'(guess_hist[c]);
      end
    end
  end

endmodule

// File: rtl/peg_scorer.sv
// peg_scorer: Mastermind-style scorer. Code and guess slots are loaded from
// colour_in; the score is accumulated one slot per compare step and the
// result is registered on the cycle after the step flagged reach_result_3.
//   clk, resetn - clock and synchronous active-low reset
//   bus         - peg_scorer_if.slave, see the interface for signal meanings
// Optional feature: define PEG_SCORER_GUESS_LIMIT_EN to end the game after
// MAX_GUESSES non-winning scores; otherwise game_over is constant 0.
module peg_scorer
  import mm_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  peg_scorer_if.slave bus
);

  colour_t [NUM_PEGS-1:0] code_q, code_d;
  colour_t [NUM_PEGS-1:0] guess_q, guess_d;
  hist_arr_t              code_hist_q, code_hist_d;
  hist_arr_t              guess_hist_q, guess_hist_d;
  hist_t                  black_acc_q, black_acc_d;
  logic                   armed_q, armed_d;
  logic                   pending_q, pending_d;
  logic [2:0]             black_q, black_d;
  logic [2:0]             white_q, white_d;
  logic                   result_valid_q, result_valid_d;
  logic                   win_q, win_d;
  logic [3:0]             guess_count_q, guess_count_d;
  logic                   game_over_q, game_over_d;

  logic [NUM_PEGS-1:0] load_code_vec;
  logic [NUM_PEGS-1:0] load_guess_vec;
  logic [OVL_W-1:0]    overlap;
  logic [OVL_W-1:0]    white_full;
  logic                step_blocked;
  logic                step_ok;
  colour_t             code_sel;
  colour_t             guess_sel;

  assign load_code_vec  = {bus.load_code_4, bus.load_code_3, bus.load_code_2, bus.load_code_1};
  assign load_guess_vec = {bus.load_guess_4, bus.load_guess_3, bus.load_guess_2, bus.load_guess_1};

`ifdef PEG_SCORER_GUESS_LIMIT_EN
  assign step_blocked = game_over_q;
`else
  assign step_blocked = 1'b0;
`endif

  // A step only counts once slot 0 has opened a new accumulation since the last result.
  assign step_ok    = bus.compare && !step_blocked && ((bus.compare_i == 2'd0) || armed_q);
  assign code_sel   = code_q[bus.compare_i];
  assign guess_sel  = guess_q[bus.compare_i];
  assign white_full = overlap - OVL_W'(black_acc_q);

  mm_overlap u_overlap (
    .code_hist  (code_hist_q),
    .guess_hist (guess_hist_q),
    .overlap    (overlap)
  );

  always_comb begin
    code_d         = code_q;
    guess_d        = guess_q;
    code_hist_d    = code_hist_q;
    guess_hist_d   = guess_hist_q;
    black_acc_d    = black_acc_q;
    armed_d        = armed_q;
    pending_d      = 1'b0;
    black_d        = black_q;
    white_d        = white_q;
    result_valid_d = 1'b0;
    win_d          = win_q;
    guess_count_d  = guess_count_q;
    game_over_d    = game_over_q;

    for (int k = 0; k < NUM_PEGS; k++) begin
      if (load_code_vec[k]) code_d[k] = bus.colour_in;
      if (load_guess_vec[k]) guess_d[k] = bus.colour_in;
    end

    // Scoring reads the registered slots, so a load in the same cycle only affects later steps.
    if (step_ok) begin
      if (bus.compare_i == 2'd0) begin
        black_acc_d  = '0;
        code_hist_d  = '0;
        guess_hist_d = '0;
        armed_d      = 1'b1;
      end
      if (code_sel == guess_sel) black_acc_d = sat_inc4(black_acc_d);
      code_hist_d[code_sel]   = sat_inc4(code_hist_d[code_sel]);
      guess_hist_d[guess_sel] = sat_inc4(guess_hist_d[guess_sel]);
      if (bus.reach_result_3) begin
        pending_d = 1'b1;
        armed_d   = 1'b0;
      end
    end

    if (pending_q) begin
      black_d        = black_acc_q;
      white_d        = white_full[2:0];
      result_valid_d = 1'b1;
      win_d          = (black_acc_q == hist_t'(NUM_PEGS));
      guess_count_d  = (guess_count_q == 4'hF) ? guess_count_q : guess_count_q + 4'd1;
`ifdef PEG_SCORER_GUESS_LIMIT_EN
      if ((guess_count_q == 4'(MAX_GUESSES - 1)) && (black_acc_q != hist_t'(NUM_PEGS))) begin
        game_over_d = 1'b1;
      end
`endif
    end

    // Loading a new code starts a new game and overrides any result landing this cycle.
    if (|load_code_vec) begin
      black_d        = '0;
      white_d        = '0;
      win_d          = 1'b0;
      guess_count_d  = '0;
      game_over_d    = 1'b0;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      code_q         <= '0;
      guess_q        <= '0;
      code_hist_q    <= '0;
      guess_hist_q   <= '0;
      black_acc_q    <= '0;
      armed_q        <= 1'b0;
      pending_q      <= 1'b0;
      black_q        <= '0;
      white_q        <= '0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      guess_count_q  <= '0;
      game_over_q    <= 1'b0;
    end else begin
      code_q         <= code_d;
      guess_q        <= guess_d;
      code_hist_q    <= code_hist_d;
      guess_hist_q   <= guess_hist_d;
      black_acc_q    <= black_acc_d;
      armed_q        <= armed_d;
      pending_q      <= pending_d;
      black_q        <= black_d;
      white_q        <= white_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      guess_count_q  <= guess_count_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.black        = black_q;
  assign bus.white        = white_q;
  assign bus.result_valid = result_valid_q;
  assign bus.win          = win_q;
  assign bus.guess_count  = guess_count_q;
  assign bus.game_over    = game_over_q;

endmodule
